rx_peak_detector: RTL and testbench

//  Parametrised correlation-peak detector and sequence identifier for the RX chain.

---
 rtl/rx_peak_detector_if.sv | 29 ++
 rtl/rx_peak_detector.sv | 241 ++++++++++++++++++++++++
 tb/tb_rx_peak_detector.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_peak_detector_if.sv
// rtl/rx_peak_detector_if.sv - correlation input and detection report bundle
interface rx_peak_detector_if #(
  parameter int N_SEQ    = 16,
  parameter int CORR_W   = 41,
  parameter int SEQ_ID_W = 4,
  parameter int TS_W     = 32
) ();
  logic                      icorr_valid;
  logic [N_SEQ*CORR_W-1:0]   icorr_flat;
  logic [CORR_W-1:0]         ithreshold;
  logic                      odet_valid;
  logic                      idet_ready;
  logic [SEQ_ID_W-1:0]       odet_seq_id;
  logic [CORR_W-1:0]         odet_peak;
  logic [TS_W-1:0]           odet_timestamp;
  logic                      odet_overrun;

  // correlator/consumer side
  modport master (
    output icorr_valid, icorr_flat, ithreshold, idet_ready,
    input  odet_valid, odet_seq_id, odet_peak, odet_timestamp, odet_overrun
  );

  // detector side
  modport slave (
    input  icorr_valid, icorr_flat, ithreshold, idet_ready,
    output odet_valid, odet_seq_id, odet_peak, odet_timestamp, odet_overrun
  );
endinterface

// File: rtl/rx_peak_detector.sv
// rtl/rx_peak_detector.sv - correlation peak detector and sequence identifier
module rx_peak_detector #(
  parameter int N_SEQ    = 16,
  parameter int CORR_W   = 41,
  parameter int SEQ_ID_W = 4,
  parameter int TS_W     = 32,
  parameter int WIN      = 64,
  parameter int HOLDOFF  = 256
) (
  input  logic              crx_clk,
  input  logic              rrx_rst,
  input  logic              erx_en,
  rx_peak_detector_if.slave bus
);
  localparam int WC_W = $clog2(WIN + 1);
  localparam int HC_W = $clog2(HOLDOFF + 2);
  localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_TRACK   = 2'd1,
    S_REPORT  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TS_W-1:0]     tsc;
  logic [CORR_W-1:0]   mag_c [N_SEQ];
  logic                s1_valid;
  logic [CORR_W-1:0]   s1_mag [N_SEQ];
  logic [TS_W-1:0]     s1_tag;
  logic [CORR_W-1:0]   best_mag;
  logic [SEQ_ID_W-1:0] best_id;
  logic                s2_valid;
  logic [CORR_W-1:0]   s2_mag;
  logic [SEQ_ID_W-1:0] s2_id;
  logic [TS_W-1:0]     s2_tag;

  logic [SEQ_ID_W-1:0] cand_id;
  logic [CORR_W-1:0]   cand_mag;
  logic [TS_W-1:0]     cand_tag;
  logic [WC_W-1:0]     win_cnt;
  logic [HC_W-1:0]     hold_cnt;

  logic                det_valid;
  logic [SEQ_ID_W-1:0] det_id;
  logic [CORR_W-1:0]   det_peak;
  logic [TS_W-1:0]     det_ts;
  logic                det_overrun;

  logic cand_load, win_inc, out_load, over_set, hold_inc, hold_clr, ack;

  // exact two's-complement magnitude; the most negative value maps to 2^(CORR_W-1)
  always_comb begin
    for (int i = 0; i < N_SEQ; i++) begin
      mag_c[i] = bus.icorr_flat[i*CORR_W +: CORR_W];
      if (mag_c[i][CORR_W-1]) begin
        mag_c[i] = ~mag_c[i] + CORR_W'(1);
      end
    end
  end

  // stage 1: register magnitudes and tag the sample with the pre-increment timestamp
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      tsc      <= '0;
      for (int i = 0; i < N_SEQ; i++) s1_mag[i] <= '0;
    end else if (!erx_en) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      tsc      <= '0;
      for (int i = 0; i < N_SEQ; i++) s1_mag[i] <= '0;
    end else begin
      s1_valid <= bus.icorr_valid;
      if (bus.icorr_valid) begin
        for (int i = 0; i < N_SEQ; i++) s1_mag[i] <= mag_c[i];
        s1_tag <= tsc;
        tsc    <= tsc + TS_W'(1);
      end
    end
  end

  // argmax across channels; strict compare keeps the lowest index on ties
  always_comb begin
    best_mag = s1_mag[0];
    best_id  = '0;
    for (int i = 1; i < N_SEQ; i++) begin
      if (s1_mag[i] > best_mag) begin
        best_mag = s1_mag[i];
        best_id  = SEQ_ID_W'(i);
      end
    end
  end

  // stage 2: register the per-sample winner
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_id    <= '0;
      s2_tag   <= '0;
    end else if (!erx_en) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_id    <= '0;
      s2_tag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag <= best_mag;
        s2_id  <= best_id;
        s2_tag <= s1_tag;
      end
    end
  end

  // detection state register
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state <= S_SEARCH;
    end else if (!erx_en) begin
      state <= S_SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and datapath controls; the FSM only moves on a stage-2 sample or a handshake
  always_comb begin
    state_nxt = state;
    cand_load = 1'b0;
    win_inc   = 1'b0;
    out_load  = 1'b0;
    over_set  = 1'b0;
    hold_inc  = 1'b0;
    hold_clr  = 1'b0;
    ack       = 1'b0;
    case (state)
      S_SEARCH: begin
        if (s2_valid && (s2_mag > bus.ithreshold)) begin
          cand_load = 1'b1;
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (s2_valid) begin
          if (s2_mag > cand_mag) begin
            cand_load = 1'b1;
          end else if (win_cnt == WIN_LAST) begin
            out_load  = 1'b1;
            state_nxt = S_REPORT;
          end else begin
            win_inc = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (s2_valid && (s2_mag > bus.ithreshold)) begin
          over_set = 1'b1;
        end
        if (det_valid && bus.idet_ready) begin
          ack       = 1'b1;
          hold_clr  = 1'b1;
          state_nxt = (HOLDOFF == 0) ? S_SEARCH : S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (s2_valid) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = S_SEARCH;
          end else begin
            hold_inc = 1'b1;
          end
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  // candidate, counters and report registers; report fields persist after the handshake
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      cand_id     <= '0;
      cand_mag    <= '0;
      cand_tag    <= '0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      det_valid   <= 1'b0;
      det_id      <= '0;
      det_peak    <= '0;
      det_ts      <= '0;
      det_overrun <= 1'b0;
    end else if (!erx_en) begin
      cand_id     <= '0;
      cand_mag    <= '0;
      cand_tag    <= '0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      det_valid   <= 1'b0;
      det_id      <= '0;
      det_peak    <= '0;
      det_ts      <= '0;
      det_overrun <= 1'b0;
    end else begin
      if (cand_load) begin
        cand_id  <= s2_id;
        cand_mag <= s2_mag;
        cand_tag <= s2_tag;
        win_cnt  <= '0;
      end else if (win_inc) begin
        win_cnt <= win_cnt + WC_W'(1);
      end
      if (hold_clr) begin
        hold_cnt <= '0;
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + HC_W'(1);
      end
      if (out_load) begin
        det_valid <= 1'b1;
        det_id    <= cand_id;
        det_peak  <= cand_mag;
        det_ts    <= cand_tag;
      end else if (ack) begin
        det_valid <= 1'b0;
      end
      if (over_set) begin
        det_overrun <= 1'b1;
      end
    end
  end

  assign bus.odet_valid     = det_valid;
  assign bus.odet_seq_id    = det_id;
  assign bus.odet_peak      = det_peak;
  assign bus.odet_timestamp = det_ts;
  assign bus.odet_overrun   = det_overrun;
endmodule

// File: tb/tb_rx_peak_detector.sv
// tb/tb_rx_peak_detector.sv - self-checking bench for rx_peak_detector
module tb_rx_peak_detector;
  localparam int N_SEQ    = 16;
  localparam int CORR_W   = 41;
  localparam int SEQ_ID_W = 4;
  localparam int TS_W     = 4;
  localparam int WIN      = 4;
  localparam int HOLDOFF  = 3;
  localparam int RN       = 120;

  typedef struct {
    int     ch_a;
    longint val_a;
    int     ch_b;
    longint val_b;
    longint thr;
    bit     exp_rep;
    int     exp_id;
    longint exp_pk;
  } vec_t;

  typedef struct {
    int     id;
    longint pk;
    int     ts;
  } rep_t;

  logic crx_clk = 1'b0;
  logic rrx_rst;
  logic erx_en;

  always #5 crx_clk = ~crx_clk;

  rx_peak_detector_if #(.N_SEQ(N_SEQ), .CORR_W(CORR_W), .SEQ_ID_W(SEQ_ID_W), .TS_W(TS_W)) bus ();

  rx_peak_detector #(
    .N_SEQ(N_SEQ), .CORR_W(CORR_W), .SEQ_ID_W(SEQ_ID_W),
    .TS_W(TS_W), .WIN(WIN), .HOLDOFF(HOLDOFF)
  ) dut (
    .crx_clk(crx_clk),
    .rrx_rst(rrx_rst),
    .erx_en(erx_en),
    .bus(bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint smp [N_SEQ];
  longint rs [0:RN-1][0:N_SEQ-1];
  vec_t   vt [6];
  rep_t   got_q[$];
  rep_t   exp_q[$];
  bit     mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge crx_clk);
    #1;
  endtask

  task automatic send();
    bus.icorr_valid = 1'b1;
    for (int i = 0; i < N_SEQ; i++) bus.icorr_flat[i*CORR_W +: CORR_W] = CORR_W'(smp[i]);
    tick();
    bus.icorr_valid = 1'b0;
  endtask

  task automatic one(input int ch, input longint v);
    for (int i = 0; i < N_SEQ; i++) smp[i] = 0;
    smp[ch] = v;
    send();
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) one(0, 0);
  endtask

  task automatic clear_en();
    bus.icorr_valid = 1'b0;
    bus.idet_ready  = 1'b0;
    erx_en = 1'b0;
    tick();
    erx_en = 1'b1;
  endtask

  task automatic handshake();
    bus.idet_ready = 1'b1;
    tick();
    bus.idet_ready = 1'b0;
  endtask

  task automatic chk_rep(input string name, input int id, input longint pk, input int ts);
    check({name, "_valid"}, bus.odet_valid, 1);
    check({name, "_id"}, bus.odet_seq_id, id);
    check({name, "_peak"}, bus.odet_peak, pk);
    check({name, "_ts"}, bus.odet_timestamp, ts);
  endtask

  // reference: scan the sample list, no cycle detail beyond "a report does not consume a sample"
  task automatic model(input longint thr);
    longint mg [RN];
    int     id [RN];
    longint a;
    int     p, best, k, quiet;
    for (int s = 0; s < RN; s++) begin
      mg[s] = -1;
      id[s] = 0;
      for (int c = 0; c < N_SEQ; c++) begin
        a = (rs[s][c] < 0) ? -rs[s][c] : rs[s][c];
        if (a > mg[s]) begin
          mg[s] = a;
          id[s] = c;
        end
      end
    end
    p = 0;
    while (p < RN) begin
      if (mg[p] > thr) begin
        best = p;
        k = p + 1;
        quiet = 0;
        while (k < RN && quiet < WIN) begin
          if (mg[k] > mg[best]) begin
            best = k;
            quiet = 0;
          end else begin
            quiet++;
          end
          k++;
        end
        if (quiet < WIN) break;
        exp_q.push_back('{id[best], mg[best], best % (1 << TS_W)});
        p = k + HOLDOFF;
      end else begin
        p++;
      end
    end
  endtask

  always @(negedge crx_clk) begin
    if (mon_en && bus.odet_valid && bus.idet_ready)
      got_q.push_back('{int'(bus.odet_seq_id), longint'(bus.odet_peak), int'(bus.odet_timestamp)});
  end

  initial begin
    longint thr;
    int     c, n;
    longint m;

    vt[0] = '{3, 500, 9, 500, 100, 1'b1, 3, 500};
    vt[1] = '{7, -(longint'(1) << 40), 0, 0, 100, 1'b1, 7, longint'(1) << 40};
    vt[2] = '{15, -1000, 0, 999, 500, 1'b1, 15, 1000};
    vt[3] = '{0, (longint'(1) << 40) - 1, 1, -((longint'(1) << 40) - 1), 0, 1'b1, 0, (longint'(1) << 40) - 1};
    vt[4] = '{4, 150, 5, -150, 150, 1'b0, 0, 0};
    vt[5] = '{12, -151, 2, 0, 150, 1'b1, 12, 151};

    rrx_rst = 1'b1;
    erx_en  = 1'b1;
    bus.icorr_valid = 1'b0;
    bus.icorr_flat  = '0;
    bus.ithreshold  = '0;
    bus.idet_ready  = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.odet_valid, 0);
    check("rst_id", bus.odet_seq_id, 0);
    check("rst_peak", bus.odet_peak, 0);
    check("rst_ts", bus.odet_timestamp, 0);
    check("rst_overrun", bus.odet_overrun, 0);
    rrx_rst = 1'b0;
    tick();

    // table: single over-threshold sample followed by WIN quiet samples
    for (int k = 0; k < 6; k++) begin
      clear_en();
      bus.ithreshold = CORR_W'(vt[k].thr);
      for (int i = 0; i < N_SEQ; i++) smp[i] = 0;
      smp[vt[k].ch_a] = vt[k].val_a;
      smp[vt[k].ch_b] = vt[k].val_b;
      send();
      zeros(WIN);
      tick();
      tick();
      tick();
      check($sformatf("vec%0d_valid", k), bus.odet_valid, vt[k].exp_rep);
      if (vt[k].exp_rep) begin
        check($sformatf("vec%0d_id", k), bus.odet_seq_id, vt[k].exp_id);
        check($sformatf("vec%0d_peak", k), bus.odet_peak, vt[k].exp_pk);
        check($sformatf("vec%0d_ts", k), bus.odet_timestamp, 0);
      end
    end

    // rising/falling peak on ch5, latency from the confirming sample
    clear_en();
    bus.ithreshold = 150;
    zeros(10);
    one(5, 100); one(5, 200); one(5, 300); one(5, 250); one(5, 240); one(5, 230); one(5, -220);
    check("t1_lat1", bus.odet_valid, 0);
    tick();
    check("t1_lat2", bus.odet_valid, 0);
    tick();
    chk_rep("t1", 5, 300, 12);
    handshake();
    check("t1_drop", bus.odet_valid, 0);
    check("t1_keep_peak", bus.odet_peak, 300);
    check("t1_keep_id", bus.odet_seq_id, 5);

    // overrun while pending, then holdoff ignores the next HOLDOFF samples
    clear_en();
    bus.ithreshold = 150;
    one(2, 400);
    zeros(WIN);
    tick(); tick(); tick();
    chk_rep("t4a", 2, 400, 0);
    check("t4_ovr0", bus.odet_overrun, 0);
    one(4, 900);
    tick(); tick(); tick();
    chk_rep("t4b", 2, 400, 0);
    check("t4_ovr1", bus.odet_overrun, 1);
    handshake();
    check("t4_drop", bus.odet_valid, 0);
    one(6, 1000); one(6, 1000); one(6, 1000);
    one(6, 200);
    zeros(WIN);
    tick(); tick(); tick();
    chk_rep("t4c", 6, 200, 9);
    check("t4_ovr_sticky", bus.odet_overrun, 1);

    // asynchronous reset during TRACK
    clear_en();
    bus.ithreshold = 150;
    one(1, 300);
    zeros(WIN);
    tick(); tick(); tick();
    handshake();
    zeros(HOLDOFF);
    one(3, 700);
    one(0, 0);
    tick(); tick(); tick();
    check("t5_pre_id", bus.odet_seq_id, 1);
    check("t5_pre_peak", bus.odet_peak, 300);
    #2;
    rrx_rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.odet_valid, 0);
    check("t5_rst_id", bus.odet_seq_id, 0);
    check("t5_rst_peak", bus.odet_peak, 0);
    check("t5_rst_ts", bus.odet_timestamp, 0);
    @(negedge crx_clk);
    rrx_rst = 1'b0;
    tick();
    one(0, 0); one(0, 0); one(8, 250);
    zeros(WIN);
    tick(); tick(); tick();
    chk_rep("t5", 8, 250, 2);

    // timestamp wrap and enable-low clear while a report is pending
    clear_en();
    bus.ithreshold = 150;
    zeros(16);
    one(11, 300);
    zeros(WIN);
    tick(); tick(); tick();
    chk_rep("t6", 11, 300, 0);
    erx_en = 1'b0;
    tick();
    check("t6_en_valid", bus.odet_valid, 0);
    check("t6_en_peak", bus.odet_peak, 0);
    check("t6_en_id", bus.odet_seq_id, 0);
    erx_en = 1'b1;

    // randomized stream against the scan model; gaps keep samples out of the one-clock REPORT
    clear_en();
    thr = longint'($urandom_range(700, 450));
    bus.ithreshold = CORR_W'(thr);
    bus.idet_ready = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < RN; k++) begin
      for (int i = 0; i < N_SEQ; i++) rs[k][i] = longint'($urandom_range(800, 0)) - 400;
      if ($urandom_range(3, 0) == 0) begin
        c = int'($urandom_range(N_SEQ - 1, 0));
        m = longint'($urandom_range(2000, 300));
        rs[k][c] = ($urandom_range(1, 0) == 1) ? m : -m;
      end
      for (int i = 0; i < N_SEQ; i++) smp[i] = rs[k][i];
      send();
      repeat ($urandom_range(3, 1)) tick();
    end
    repeat (12) tick();
    mon_en = 1'b0;
    bus.idet_ready = 1'b0;
    model(thr);
    check("rnd_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("rnd%0d_id", i), got_q[i].id, exp_q[i].id);
      check($sformatf("rnd%0d_peak", i), got_q[i].pk, exp_q[i].pk);
      check($sformatf("rnd%0d_ts", i), got_q[i].ts, exp_q[i].ts);
    end
    check("rnd_overrun", bus.odet_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
